// File: rtl/recorder_pkg.sv
// Shared types and defaults for the track recorder controller.
package recorder_pkg;

   localparam int ADDR_WIDTH_DEFAULT = 16;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RECORD = 2'd1,
      PLAY   = 2'd2
   } state_t;

endpackage

// File: rtl/edge_detector.sv
// Single-bit rising-edge detector. History powers up high so a level that is
// already asserted when reset releases never reports an edge.
module edge_detector (
   input  logic clock,
   input  logic reset_n,
   input  logic level,
   output logic rise
);

   logic level_q;

   // Previous-cycle copy of the level.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) level_q <= 1'b1;
      else          level_q <= level;
   end

   assign rise = level & ~level_q;

endmodule

// File: rtl/recorder_controller.sv
// Two-track sample recorder/player sequencer. Drives the address, bank and
// write strobe of an external sample memory and tracks per-track lengths.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | waiting for a record or play button event
//   RECORD | one write per sample_tick into mem_track, stops on button/full
//   PLAY   | one address step per sample_tick until the track length
module recorder_controller
   import recorder_pkg::*;
#(
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
   parameter int NUM_TRACKS = 2
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  play_button,
   input  logic                  record_button,
   input  logic                  play_track_switch,
   input  logic                  record_track_switch,
   input  logic                  sample_tick,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_track,
   output logic                  mem_we,
   output logic                  play_en,
   output logic                  rec_led,
   output logic                  play_led
);

   localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = '0;
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH-1:0] ADDR_MAX  = '1;
   localparam logic [ADDR_WIDTH:0]   LEN_ZERO  = '0;
   localparam logic [ADDR_WIDTH:0]   LEN_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

   state_t                state, state_nxt;
   logic [ADDR_WIDTH-1:0] addr_nxt;
   logic                  track_nxt;
   logic                  we_nxt;
   logic [ADDR_WIDTH:0]   track_len     [NUM_TRACKS];
   logic [ADDR_WIDTH:0]   track_len_nxt [NUM_TRACKS];
   logic                  play_evt, rec_evt;
   logic [ADDR_WIDTH:0]   rec_count;
   logic                  play_last;

   edge_detector u_play_edge (
      .clock   (clock),
      .reset_n (reset_n),
      .level   (play_button),
      .rise    (play_evt)
   );

   edge_detector u_rec_edge (
      .clock   (clock),
      .reset_n (reset_n),
      .level   (record_button),
      .rise    (rec_evt)
   );

   // A strobe that is high this cycle is a write in flight; it counts toward the length.
   assign rec_count = {1'b0, mem_addr} + (mem_we ? LEN_ONE : LEN_ZERO);
   assign play_last = ({1'b0, mem_addr} == (track_len[mem_track] - LEN_ONE));

   // State, outputs and lengths all register the next-value logic below.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         mem_addr  <= ADDR_ZERO;
         mem_track <= 1'b0;
         mem_we    <= 1'b0;
         play_en   <= 1'b0;
         rec_led   <= 1'b0;
         play_led  <= 1'b0;
         for (int i = 0; i < NUM_TRACKS; i++) track_len[i] <= LEN_ZERO;
      end else begin
         state     <= state_nxt;
         mem_addr  <= addr_nxt;
         mem_track <= track_nxt;
         mem_we    <= we_nxt;
         play_en   <= (state_nxt == PLAY);
         rec_led   <= (state_nxt == RECORD);
         play_led  <= (state_nxt == PLAY);
         for (int i = 0; i < NUM_TRACKS; i++) track_len[i] <= track_len_nxt[i];
      end
   end

   // Next-state, address, strobe and length decisions.
   always_comb begin
      state_nxt = state;
      addr_nxt  = mem_addr;
      track_nxt = mem_track;
      we_nxt    = 1'b0;
      for (int i = 0; i < NUM_TRACKS; i++) track_len_nxt[i] = track_len[i];

      case (state)
         IDLE: begin
            // Record wins over a simultaneous play event.
            if (rec_evt) begin
               state_nxt = RECORD;
               addr_nxt  = ADDR_ZERO;
               track_nxt = record_track_switch;
            end else if (play_evt && (track_len[play_track_switch] != LEN_ZERO)) begin
               state_nxt = PLAY;
               addr_nxt  = ADDR_ZERO;
               track_nxt = play_track_switch;
            end
         end

         RECORD: begin
            if (rec_evt) begin
               state_nxt                = IDLE;
               addr_nxt                 = ADDR_ZERO;
               track_len_nxt[mem_track] = rec_count;
            end else if (mem_we && (mem_addr == ADDR_MAX)) begin
               // Last location written: stop rather than wrap onto address 0.
               state_nxt                = IDLE;
               addr_nxt                 = ADDR_ZERO;
               track_len_nxt[mem_track] = rec_count;
            end else begin
               if (mem_we) addr_nxt = mem_addr + ADDR_ONE;
               we_nxt = sample_tick;
            end
         end

         PLAY: begin
            if (play_evt) begin
               state_nxt = IDLE;
               addr_nxt  = ADDR_ZERO;
            end else if (sample_tick) begin
               if (play_last) begin
                  state_nxt = IDLE;
                  addr_nxt  = ADDR_ZERO;
               end else begin
                  addr_nxt = mem_addr + ADDR_ONE;
               end
            end
         end

         default: begin
            state_nxt = IDLE;
            addr_nxt  = ADDR_ZERO;
         end
      endcase
   end

endmodule

// File: tb/tb_recorder_controller.sv
// Directed plus randomized bench for recorder_controller at ADDR_WIDTH=4.
// The reference model only knows track lengths: a take of k ticks stores
// min(k, depth) samples and playback lasts exactly that many ticks.
module tb_recorder_controller;

   localparam int AW    = 4;
   localparam int DEPTH = 1 << AW;

   logic          clock = 1'b0;
   logic          reset_n;
   logic          play_button;
   logic          record_button;
   logic          play_track_switch;
   logic          record_track_switch;
   logic          sample_tick;
   logic [AW-1:0] mem_addr;
   logic          mem_track;
   logic          mem_we;
   logic          play_en;
   logic          rec_led;
   logic          play_led;

   int checks        = 0;
   int errors        = 0;
   int we_violations = 0;
   int model_len [2];

   typedef struct {
      logic track;
      int   addr;
   } wr_t;

   wr_t wr_q [$];
   wr_t mon_w;

   recorder_controller #(.ADDR_WIDTH(AW), .NUM_TRACKS(2)) dut (
      .clock               (clock),
      .reset_n             (reset_n),
      .play_button         (play_button),
      .record_button       (record_button),
      .play_track_switch   (play_track_switch),
      .record_track_switch (record_track_switch),
      .sample_tick         (sample_tick),
      .mem_addr            (mem_addr),
      .mem_track           (mem_track),
      .mem_we              (mem_we),
      .play_en             (play_en),
      .rec_led             (rec_led),
      .play_led            (play_led)
   );

   always #5 clock = ~clock;

   // Write monitor: logs every strobe cycle and flags strobes outside RECORD.
   always @(negedge clock) begin
      if (mem_we === 1'b1) begin
         mon_w.track = mem_track;
         mon_w.addr  = int'(mem_addr);
         wr_q.push_back(mon_w);
         if (rec_led !== 1'b1) we_violations++;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic press_record();
      record_button = 1'b1;
      step(1);
      record_button = 1'b0;
      step(1);
   endtask

   task automatic press_play();
      play_button = 1'b1;
      step(1);
      play_button = 1'b0;
      step(1);
   endtask

   task automatic do_tick(input int gap);
      sample_tick = 1'b1;
      step(1);
      sample_tick = 1'b0;
      step(gap);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_addr"},  mem_addr,  0);
      check({tag, "_track"}, mem_track, 0);
      check({tag, "_we"},    mem_we,    0);
      check({tag, "_play"},  play_en,   0);
      check({tag, "_rled"},  rec_led,   0);
      check({tag, "_pled"},  play_led,  0);
   endtask

   task automatic record_take(input logic track, input int k, input bit early);
      int n;
      n = (k < DEPTH) ? k : DEPTH;
      wr_q.delete();
      record_track_switch = track;
      press_record();
      check("rec_start_led",   rec_led,   1);
      check("rec_start_track", mem_track, track);
      record_track_switch = ~track;
      for (int i = 0; i < k; i++) begin
         sample_tick = 1'b1;
         step(1);
         sample_tick = 1'b0;
         if (!(early && i == k - 1)) step($urandom_range(1, 3));
      end
      if (k < DEPTH) begin
         check("rec_led_before_stop", rec_led, 1);
         press_record();
      end
      step(3);
      check("rec_stop_led",    rec_led,     0);
      check("rec_write_count", wr_q.size(), n);
      for (int i = 0; i < wr_q.size(); i++) begin
         check("rec_write_addr",  wr_q[i].addr,  i);
         check("rec_write_track", wr_q[i].track, track);
      end
      model_len[track] = n;
   endtask

   task automatic play_take(input logic track, input int len);
      play_track_switch = track;
      press_play();
      if (len == 0) begin
         check("play_empty_en",  play_en,  0);
         check("play_empty_led", play_led, 0);
      end else begin
         check("play_start_track", mem_track, track);
         play_track_switch = ~track;
         for (int i = 0; i < len; i++) begin
            check("play_en_during", play_en,  1);
            check("play_addr",      mem_addr, i);
            do_tick($urandom_range(1, 3));
         end
         check("play_end_en",   play_en,  0);
         check("play_end_led",  play_led, 0);
         check("play_end_addr", mem_addr, 0);
      end
   endtask

   initial begin
      reset_n             = 1'b0;
      play_button         = 1'b0;
      record_button       = 1'b0;
      play_track_switch   = 1'b0;
      record_track_switch = 1'b0;
      sample_tick         = 1'b0;
      model_len[0]        = 0;
      model_len[1]        = 0;
      step(2);
      check_all_zero("reset");
      reset_n = 1'b1;
      step(2);

      // Empty track after reset never starts playback.
      play_take(1'b1, model_len[1]);

      // Short take on track 0 and its playback.
      record_take(1'b0, 5, 1'b0);
      play_take(1'b0, model_len[0]);

      // Overlong take on track 1 auto-stops at full depth.
      record_take(1'b1, 20, 1'b0);
      play_take(1'b1, model_len[1]);

      // Play ignored while recording; record ignored while playing; play stops playback.
      wr_q.delete();
      record_track_switch = 1'b0;
      press_record();
      press_play();
      check("rec_ignores_play_r", rec_led,  1);
      check("rec_ignores_play_p", play_led, 0);
      do_tick(2);
      do_tick(2);
      press_record();
      check("rec2_stop", rec_led,     0);
      check("rec2_cnt",  wr_q.size(), 2);
      model_len[0] = 2;
      play_track_switch = 1'b0;
      press_play();
      check("play2_start", play_led, 1);
      press_record();
      check("play_ignores_rec_p", play_led, 1);
      check("play_ignores_rec_r", rec_led,  0);
      do_tick(1);
      check("play2_addr1", mem_addr, 1);
      press_play();
      check("play2_stop_en",   play_en,  0);
      check("play2_stop_addr", mem_addr, 0);

      // Simultaneous events select RECORD; a held button is one event.
      record_track_switch = 1'b1;
      record_button = 1'b1;
      play_button   = 1'b1;
      step(1);
      check("simul_rec",  rec_led,  1);
      check("simul_play", play_led, 0);
      play_button = 1'b0;
      step(100);
      check("held_single_event", rec_led, 1);
      record_button = 1'b0;
      step(1);
      check("held_release", rec_led, 1);
      press_record();
      check("held_stop", rec_led, 0);
      model_len[1] = 0;
      play_take(1'b1, model_len[1]);

      // Randomized takes and playbacks against the length model.
      for (int it = 0; it < 8; it++) begin
         logic rt, pt;
         int   k;
         bit   early;
         rt    = ($urandom_range(0, 1) == 1);
         pt    = ($urandom_range(0, 1) == 1);
         k     = $urandom_range(0, 20);
         early = ($urandom_range(0, 1) == 1);
         record_take(rt, k, early);
         play_take(pt, model_len[pt]);
      end

      // Reset mid-record at address 3 with both buttons held through release.
      wr_q.delete();
      record_track_switch = 1'b0;
      press_record();
      do_tick(2);
      do_tick(2);
      do_tick(2);
      check("prereset_addr", mem_addr, 3);
      check("prereset_rled", rec_led,  1);
      reset_n       = 1'b0;
      play_button   = 1'b1;
      record_button = 1'b1;
      #1;
      check_all_zero("async_reset");
      step(2);
      reset_n = 1'b1;
      step(5);
      check("held_through_reset_r", rec_led,  0);
      check("held_through_reset_p", play_led, 0);
      check("held_through_reset_e", play_en,  0);
      play_button   = 1'b0;
      record_button = 1'b0;
      step(2);
      check("reset_no_extra_write", wr_q.size(), 3);
      model_len[0] = 0;
      model_len[1] = 0;
      play_take(1'b0, model_len[0]);
      play_take(1'b1, model_len[1]);

      check("we_outside_record", we_violations, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/recorder_controller.md
RECORDER_CONTROLLER -- requirements
Module: recorder_controller

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, gives the sample-memory address width per track.
REQ-002 Parameter NUM_TRACKS, default 2, is fixed at 2; track select is 1 bit.
REQ-003 clock  in  1  system clock; all state changes on its rising edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 play_button  in  1  synchronized play button, level.
REQ-006 record_button  in  1  synchronized record button, level.
REQ-007 play_track_switch  in  1  synchronized track select for playback.
REQ-008 record_track_switch  in  1  synchronized track select for recording.
REQ-009 sample_tick  in  1  one-cycle pulse per audio sample period.
REQ-010 mem_addr  out  ADDR_WIDTH  sample-memory address.
REQ-011 mem_track  out  1  track bank currently addressed.
REQ-012 mem_we  out  1  sample-memory write strobe, one cycle per recorded sample.
REQ-013 play_en  out  1  high while in PLAY; gates the audio output path.
REQ-014 rec_led, play_led  out  1 each  status indicators, high in RECORD and PLAY respectively.

Function
REQ-015 Button events SHALL be rising edges: level high now, registered level low on the previous cycle; a held button SHALL produce exactly one event.
REQ-016 The FSM SHALL have the states IDLE, RECORD and PLAY.
REQ-017 IDLE + record event: go to RECORD; mem_addr=0; latch mem_track=record_track_switch.
REQ-018 IDLE + play event: go to PLAY with mem_addr=0 and mem_track=play_track_switch if that track's length is nonzero; otherwise stay in IDLE.
REQ-019 A simultaneous record and play event in IDLE SHALL select RECORD.
REQ-020 RECORD, sample_tick at address N: mem_we=1 with mem_addr=N on the next cycle only; mem_addr=N+1 on the cycle after.
REQ-021 RECORD + record event: return to IDLE; length[mem_track]=number of samples written, including a write already pending.
REQ-022 RECORD, write at address 2^ADDR_WIDTH-1: after the write, length=2^ADDR_WIDTH; go to IDLE with no wrap-around.
REQ-023 A play event in RECORD SHALL be ignored.
REQ-024 PLAY, sample_tick: mem_addr increments by 1; the tick at address length-1 returns to IDLE and mem_addr=0.
REQ-025 PLAY + play event: stop immediately to IDLE; a record event in PLAY SHALL be ignored.
REQ-026 Track switches SHALL be sampled only at operation start; changes mid-operation SHALL have no effect.
REQ-027 Each length register SHALL be ADDR_WIDTH+1 bits, range 0..2^ADDR_WIDTH; a new recording on a track SHALL overwrite that track's length.
REQ-028 All outputs SHALL be registered; mem_we SHALL never assert outside RECORD.

Reset
REQ-029 On reset_n low: state=IDLE; mem_addr=0; mem_track=0; mem_we=0; play_en=0; rec_led=0; play_led=0; both lengths=0.
REQ-030 Edge-detect history registers SHALL reset to 1, so a button held through reset produces no event.
REQ-031 Reset asserted mid-RECORD or mid-PLAY SHALL abort the operation with no further mem_we pulse and SHALL clear the lengths.

Structure
REQ-032 Package recorder_pkg SHALL hold the state_t enum (IDLE, RECORD, PLAY) and the default ADDR_WIDTH constant.
REQ-033 One sub-module, edge_detector (1-bit rising edge, async active-low reset, history resets to 1), SHALL be instantiated once for play_button and once for record_button.
REQ-034 The controller SHALL contain no memory array; storage is external.

Verification (ADDR_WIDTH=4)
REQ-035 Record track 0, 5 ticks, then record event -> 5 mem_we pulses at addresses 0..4 with mem_track=0; length0=5; state IDLE.
REQ-036 Then play track 0 -> play_en high for exactly 5 ticks; mem_addr steps 0..4; IDLE after the 5th tick.
REQ-037 Record track 1 with 20 ticks -> 16 writes at addresses 0..15; auto-stop; length1=16; no write to address 0 after the stop.
REQ-038 Play event with play_track_switch=1 on an empty track 1 (after reset) -> remains IDLE, play_en=0.
REQ-039 Record and play buttons rise on the same cycle in IDLE -> RECORD; record_button held 100 cycles -> a single event.
REQ-040 reset_n low during RECORD at address 3 -> all outputs 0 asynchronously; buttons held through reset release -> no event.
